sram_req_ctrl: RTL

Request-side controller directly upstream of the 128×32 byte-enabled SRAM macro. It accepts byte-addressed load/store requests from the core over a valid/ready handshake and generates the SRAM's `addr_sel`/`byte_sel`/`datain` and single-cycle `read_pulse`/`write_pulse`. It captures `dataout`, lane-extracts and sign/zero-extends load data, and returns a response over a second valid/ready handshake. One transaction is in flight at a time.

---
 rtl/sram_req_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sram_req_ctrl.sv
// Request-side controller for a 128x32 byte-enabled SRAM: one load/store in flight, 3-cycle access.
// Optional build macro SRAM_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module sram_req_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [8:0]  req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [6:0]  sram_addr_sel,
    output logic [3:0]  sram_byte_sel,
    output logic        sram_read_pulse,
    output logic        sram_write_pulse,
    output logic [31:0] sram_datain,
    input  logic [31:0] sram_dataout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]  state;
    logic        op_we;
    logic        op_unsigned;
    logic [1:0]  op_size;
    logic [1:0]  op_off;

    logic [8:0]  eff_addr;
    logic        req_err;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        eff_addr  = req_addr;
        req_err   = (req_size == 2'b11);
`ifdef SRAM_MISALIGN_TRAP_EN
        if (req_size == SZ_HALF && req_addr[0])
            req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`else
        if (req_size == SZ_HALF)
            eff_addr[0] = 1'b0;
        if (req_size == SZ_WORD)
            eff_addr[1:0] = 2'b00;
`endif
        be_nxt    = 4'b0000;
        wdata_nxt = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                be_nxt    = 4'b0001 << eff_addr[1:0];
                wdata_nxt = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_nxt    = 4'b0011 << {eff_addr[1], 1'b0};
                wdata_nxt = {2{req_wdata[15:0]}};
            end
            SZ_WORD: be_nxt = 4'b1111;
            default: be_nxt = 4'b0000;
        endcase
    end

    // Lane extraction uses the offset captured at accept, since req_addr may change afterwards.
    always_comb begin
        lane_byte = sram_dataout[{op_off, 3'b000} +: 8];
        lane_half = op_off[1] ? sram_dataout[31:16] : sram_dataout[15:0];
        case (op_size)
            SZ_BYTE: load_data = op_unsigned ? {24'h0, lane_byte}
                                             : {{24{lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = op_unsigned ? {16'h0, lane_half}
                                             : {{16{lane_half[15]}}, lane_half};
            default: load_data = sram_dataout;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            op_we            <= 1'b0;
            op_unsigned      <= 1'b0;
            op_size          <= 2'b00;
            op_off           <= 2'b00;
            resp_valid       <= 1'b0;
            resp_err         <= 1'b0;
            resp_rdata       <= 32'h0;
            sram_addr_sel    <= 7'h0;
            sram_byte_sel    <= 4'h0;
            sram_datain      <= 32'h0;
            sram_read_pulse  <= 1'b0;
            sram_write_pulse <= 1'b0;
        end else begin
            sram_read_pulse  <= 1'b0;
            sram_write_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        sram_addr_sel <= eff_addr[8:2];
                        sram_byte_sel <= be_nxt;
                        sram_datain   <= wdata_nxt;
                        op_we         <= req_we;
                        op_unsigned   <= req_unsigned;
                        op_size       <= req_size;
                        op_off        <= eff_addr[1:0];
                        resp_rdata    <= 32'h0;
                        resp_err      <= req_err;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    state            <= PULSE;
                    sram_read_pulse  <= !op_we;
                    sram_write_pulse <= op_we;
                end
                PULSE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= op_we ? 32'h0 : load_data;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
